// File: rtl/ultrasonic_ranger.sv
// Ultrasonic ranger: triggers the sensor, times the echo pulse and reports distance in cm.
// The result registers load on the edge that enters DONE, so dist_valid and the new dist_cm/obstacle/timeout appear in the same cycle.
module ultrasonic_ranger #(
  parameter int TRIG_CYCLES    = 500,
  parameter int CYCLES_PER_CM  = 2900,
  parameter int WAIT_TIMEOUT   = 1_500_000,
  parameter int HOLDOFF_CYCLES = 3_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       echo,
  input  logic [7:0] threshold,
  output logic       trig,
  output logic [7:0] dist_cm,
  output logic       dist_valid,
  output logic       obstacle,
  output logic       timeout
);

  localparam int TW = (TRIG_CYCLES    > 1) ? $clog2(TRIG_CYCLES)    : 1;
  localparam int WW = (WAIT_TIMEOUT   > 1) ? $clog2(WAIT_TIMEOUT)   : 1;
  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam int SW = (CYCLES_PER_CM  > 1) ? $clog2(CYCLES_PER_CM)  : 1;

  localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);
  localparam logic [SW-1:0] SUB_LAST  = SW'(CYCLES_PER_CM - 1);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    DONE,
    HOLDOFF
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          echo_m;
  logic          echo_s;
  logic [TW-1:0] trig_cnt;
  logic [WW-1:0] wait_cnt;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] sub_cnt;
  logic [7:0]    cm_cnt;

  logic          cnt_en;
  logic [7:0]    res_nxt;
  logic          flag_nxt;
  logic          done_nxt;
  logic          sub_wrap;
  logic [SW-1:0] sub_step;
  logic [7:0]    cm_step;

  assign sub_wrap = (sub_cnt == SUB_LAST);
  assign sub_step = sub_wrap ? '0 : sub_cnt + SW'(1);
  assign cm_step  = sub_wrap ? cm_cnt + 8'd1 : cm_cnt;
  assign done_nxt = (state_nxt == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      echo_m <= 1'b0;
      echo_s <= 1'b0;
    end else begin
      state  <= state_nxt;
      echo_m <= echo;
      echo_s <= echo_m;
    end
  end

  // The WAIT_RISE cycle that sees echo_s high is counted too, so every high cycle contributes.
  always_comb begin
    state_nxt = state;
    cnt_en    = 1'b0;
    res_nxt   = cm_cnt;
    flag_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (ena) state_nxt = TRIG;
      end
      TRIG: begin
        if (trig_cnt == TRIG_LAST) state_nxt = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (echo_s) begin
          state_nxt = MEASURE;
          cnt_en    = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = DONE;
          res_nxt   = 8'd255;
          flag_nxt  = 1'b1;
        end
      end
      MEASURE: begin
        if (!echo_s) begin
          state_nxt = DONE;
        end else begin
          cnt_en = 1'b1;
          if (sub_wrap && cm_cnt == 8'd254) begin
            state_nxt = DONE;
            res_nxt   = 8'd255;
            flag_nxt  = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = HOLDOFF;
      end
      HOLDOFF: begin
        if (hold_cnt == HOLD_LAST) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Phase counters clear whenever their state is left, so none of them ever wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_cnt <= '0;
      wait_cnt <= '0;
      hold_cnt <= '0;
      sub_cnt  <= '0;
      cm_cnt   <= '0;
    end else begin
      trig_cnt <= (state == TRIG && trig_cnt != TRIG_LAST) ? trig_cnt + TW'(1) : '0;
      wait_cnt <= (state == WAIT_RISE && wait_cnt != WAIT_LAST) ? wait_cnt + WW'(1) : '0;
      hold_cnt <= (state == HOLDOFF && hold_cnt != HOLD_LAST) ? hold_cnt + HW'(1) : '0;
      if (cnt_en) begin
        sub_cnt <= sub_step;
        cm_cnt  <= cm_step;
      end else if (state != MEASURE) begin
        sub_cnt <= '0;
        cm_cnt  <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trig       <= 1'b0;
      dist_cm    <= 8'd0;
      dist_valid <= 1'b0;
      obstacle   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      trig       <= (state_nxt == TRIG);
      dist_valid <= done_nxt;
      if (done_nxt) begin
        dist_cm  <= res_nxt;
        timeout  <= flag_nxt;
        obstacle <= (res_nxt < threshold);
      end
    end
  end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Bench for ultrasonic_ranger: table of echo scenarios (fixed + random) against a distance model, plus reset/saturation sequences.
module tb_ultrasonic_ranger;

  localparam int TC  = 4;
  localparam int CPC = 3;
  localparam int WT  = 20;
  localparam int HC  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       echo;
  logic [7:0] threshold;
  logic       trig;
  logic [7:0] dist_cm;
  logic       dist_valid;
  logic       obstacle;
  logic       timeout;

  int tests = 0;
  int fails = 0;
  int prev_dist = 0;

  typedef struct {
    int delay;
    int high;
    int thr;
    int ena_off;
    int exp_dist;
    int exp_obs;
    int exp_to;
  } vec_t;

  vec_t vecs[17];

  always #5 clk = ~clk;

  ultrasonic_ranger #(
    .TRIG_CYCLES(TC),
    .CYCLES_PER_CM(CPC),
    .WAIT_TIMEOUT(WT),
    .HOLDOFF_CYCLES(HC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .echo(echo),
    .threshold(threshold),
    .trig(trig),
    .dist_cm(dist_cm),
    .dist_valid(dist_valid),
    .obstacle(obstacle),
    .timeout(timeout)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Distance model: N echo-high cycles give floor(N/CPC) cm; no echo or >=255 cm reads 255 with timeout.
  function automatic vec_t mk(input int d, input int h, input int t, input int off);
    vec_t v;
    v.delay   = d;
    v.high    = h;
    v.thr     = t;
    v.ena_off = off;
    if (h == 0 || h >= 255 * CPC) begin
      v.exp_dist = 255;
      v.exp_to   = 1;
    end else begin
      v.exp_dist = h / CPC;
      v.exp_to   = 0;
    end
    v.exp_obs = (v.exp_dist < t) ? 1 : 0;
    return v;
  endfunction

  // Returns at the first falling-edge sample with trig low after a trig pulse.
  task automatic wait_trig(output int width);
    int w;
    w = 0;
    while (trig !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("trig_rise", trig, 1);
    width = 0;
    while (trig === 1'b1 && width < 100) begin
      @(negedge clk);
      width++;
    end
  endtask

  task automatic run_meas(input vec_t v);
    int k;
    int got_k;
    int width;
    int exp_k;
    bit got;
    threshold = v.thr[7:0];
    check("hold_dist", dist_cm, prev_dist);
    wait_trig(width);
    check("trig_width", width, TC);
    k     = 0;
    got   = 1'b0;
    got_k = -1;
    while (!got && k < 2000) begin
      if (dist_valid === 1'b1) begin
        got   = 1'b1;
        got_k = k;
        check("dist_cm", dist_cm, v.exp_dist);
        check("obstacle", obstacle, v.exp_obs);
        check("timeout", timeout, v.exp_to);
      end else begin
        if (k == v.ena_off) ena = 1'b0;
        echo = (k >= v.delay && k < v.delay + v.high);
        @(negedge clk);
        k++;
      end
    end
    echo = 1'b0;
    // Timeout fires WT cycles into WAIT_RISE; otherwise two sync stages plus the DONE entry edge.
    exp_k = (v.high == 0) ? WT : v.delay + v.high + 3;
    check("latency", got_k, exp_k);
    @(negedge clk);
    check("strobe_width", dist_valid, 0);
    prev_dist = v.exp_dist;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int width;
    int k;
    int got_k;
    int extra;
    int trig_hi;
    rst       = 1'b1;
    ena       = 1'b0;
    echo      = 1'b0;
    threshold = 8'd0;

    vecs[0] = '{3, 30, 15, -1, 10, 1, 0};
    vecs[1] = '{3, 60, 15, -1, 20, 0, 0};
    vecs[2] = '{3, 60, 20, -1, 20, 0, 0};
    vecs[3] = '{0, 0, 15, -1, 255, 0, 1};
    for (int i = 4; i < 16; i++) begin
      int h;
      h = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(700, 1));
      vecs[i] = mk(int'($urandom_range(10, 0)), h, int'($urandom_range(255, 0)), -1);
    end
    vecs[16] = '{0, 30, 15, 10, 10, 1, 0};

    repeat (3) @(negedge clk);
    check("rst_trig", trig, 0);
    check("rst_dist", dist_cm, 0);
    check("rst_valid", dist_valid, 0);
    check("rst_obstacle", obstacle, 0);
    check("rst_timeout", timeout, 0);
    rst = 1'b0;
    ena = 1'b1;

    for (int i = 0; i < 17; i++) run_meas(vecs[i]);

    trig_hi = 0;
    extra   = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (trig === 1'b1) trig_hi++;
      if (dist_valid === 1'b1) extra++;
    end
    check("ena_off_trig", trig_hi, 0);
    check("ena_off_strobes", extra, 0);

    // Saturation: echo held for 1000 cycles stops at 255 cm (765 counted cycles).
    ena       = 1'b1;
    threshold = 8'd15;
    wait_trig(width);
    check("sat_trig_width", width, TC);
    k     = 0;
    got_k = -1;
    while (got_k < 0 && k < 1200) begin
      if (dist_valid === 1'b1) begin
        got_k = k;
        check("sat_dist", dist_cm, 255);
        check("sat_timeout", timeout, 1);
        check("sat_obstacle", obstacle, 0);
        ena = 1'b0;
      end else begin
        echo = 1'b1;
        @(negedge clk);
        k++;
      end
    end
    check("sat_latency", got_k, 255 * CPC + 2);
    extra   = 0;
    trig_hi = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      k++;
      if (k >= 1000) echo = 1'b0;
      if (dist_valid === 1'b1) extra++;
      if (trig === 1'b1) trig_hi++;
    end
    echo = 1'b0;
    check("sat_second_strobe", extra, 0);
    check("sat_idle_trig", trig_hi, 0);

    // Reset in the middle of a measurement discards it and clears the held result.
    ena = 1'b1;
    wait_trig(width);
    echo = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    ena = 1'b0;
    @(negedge clk);
    rst   = 1'b0;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) echo = 1'b0;
      @(negedge clk);
      if (dist_valid === 1'b1) extra++;
    end
    check("rst_meas_strobes", extra, 0);
    check("rst_meas_dist", dist_cm, 0);
    check("rst_meas_timeout", timeout, 0);

    // Reset during the trigger pulse drops trig on the very next edge.
    ena = 1'b1;
    k   = 0;
    while (trig !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("rst_trig_rise", trig, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_trig_drop", trig, 0);
    check("rst_trig_valid", dist_valid, 0);
    rst     = 1'b0;
    ena     = 1'b0;
    extra   = 0;
    trig_hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dist_valid === 1'b1) extra++;
      if (trig === 1'b1) trig_hi++;
    end
    check("rst_trig_strobes", extra, 0);
    check("rst_trig_idle", trig_hi, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ultrasonic_ranger.md
ULTRASONIC_RANGER -- requirements
Module: ultrasonic_ranger

Interface
REQ-001 SHALL have parameter TRIG_CYCLES, default 500, trigger pulse width in clk cycles (10 us at 50 MHz).
REQ-002 SHALL have parameter CYCLES_PER_CM, default 2900, echo-high clk cycles per centimetre.
REQ-003 SHALL have parameter WAIT_TIMEOUT, default 1_500_000, max cycles from trigger end to echo rise.
REQ-004 SHALL have parameter HOLDOFF_CYCLES, default 3_000_000, idle gap after each result before the next trigger.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port ena  input  1  enable continuous ranging.
REQ-008 SHALL have port echo  input  1  asynchronous echo line from the sensor.
REQ-009 SHALL have port threshold  input  8  obstacle distance threshold in cm.
REQ-010 SHALL have port trig  output  1  sensor trigger pulse, registered.
REQ-011 SHALL have port dist_cm  output  8  last measured distance in cm, registered.
REQ-012 SHALL have port dist_valid  output  1  one-cycle strobe when dist_cm updates.
REQ-013 SHALL have port obstacle  output  1  registered; 1 when last dist_cm < threshold.
REQ-014 SHALL have port timeout  output  1  registered; 1 when last measurement timed out or saturated.

Function
REQ-015 echo SHALL pass through a 2-flop synchronizer (echo_s); all logic uses echo_s only; both edges delayed equally.
REQ-016 FSM states SHALL be IDLE, TRIG, WAIT_RISE, MEASURE, DONE, HOLDOFF.
REQ-017 IDLE: ena=1 -> TRIG next cycle; ena=0 -> stay IDLE.
REQ-018 TRIG: trig=1 for exactly TRIG_CYCLES consecutive cycles, then -> WAIT_RISE with trig=0.
REQ-019 WAIT_RISE: echo_s=1 -> MEASURE; wait counter reaching WAIT_TIMEOUT cycles -> DONE with result 255, timeout flag set.
REQ-020 MEASURE: each cycle with echo_s=1 increments a sub-counter; at CYCLES_PER_CM-1 it wraps to 0 and the cm counter increments; result = floor(N/CYCLES_PER_CM) for N high cycles.
REQ-021 MEASURE: cm counter SHALL saturate at 255; reaching 255 -> DONE immediately with timeout flag set, no waiting for echo fall.
REQ-022 MEASURE: echo_s=0 -> DONE with timeout flag clear.
REQ-023 DONE (one cycle): dist_cm<=result, timeout<=flag, obstacle<=(result<threshold) using threshold sampled that cycle, dist_valid=1; -> HOLDOFF.
REQ-024 dist_valid SHALL be high exactly one cycle per completed measurement and never otherwise.
REQ-025 HOLDOFF: wait HOLDOFF_CYCLES cycles, then -> IDLE; echo ignored in HOLDOFF.
REQ-026 ena falling mid-measurement SHALL NOT abort; current measurement completes, then FSM stays in IDLE.
REQ-027 echo_s already high on entry to WAIT_RISE SHALL start MEASURE next cycle (no edge required).
REQ-028 dist_cm, obstacle, timeout SHALL hold their values between dist_valid strobes.
REQ-029 Counters SHALL be sized with $clog2 of their parameter; no counter may wrap except the sub-counter per REQ-020.

Reset
REQ-030 rst=1 at a clock edge SHALL force state IDLE, trig=0, dist_cm=0, dist_valid=0, obstacle=0, timeout=0, all counters and synchronizer flops=0.
REQ-031 rst asserted mid-TRIG or mid-MEASURE SHALL drop trig next edge, discard the partial result, produce no dist_valid.
REQ-032 rst SHALL dominate ena and echo on the same edge.

Verification (TRIG_CYCLES=4, CYCLES_PER_CM=3, WAIT_TIMEOUT=20, HOLDOFF_CYCLES=8)
REQ-033 rst 2 cycles, ena=1, echo high 30 cycles after trig falls, threshold=15 -> trig high exactly 4 cycles; one dist_valid; dist_cm=10, obstacle=1, timeout=0.
REQ-034 same, echo high 60 cycles, threshold=15 -> dist_cm=20, obstacle=0, timeout=0; threshold=20 -> obstacle=0 (strict compare).
REQ-035 echo never rises -> dist_valid 20 cycles after WAIT_RISE entry; dist_cm=255, timeout=1, obstacle=0 for threshold=15.
REQ-036 echo held high 1000 cycles -> dist_valid when count hits 255 (765 high cycles); dist_cm=255, timeout=1; no second strobe until HOLDOFF elapses.
REQ-037 ena=1 then cleared during MEASURE -> measurement completes with one dist_valid, then trig stays 0; rst pulse mid-TRIG -> trig 0 next cycle, no dist_valid.
